// File: rtl/mult_dot_pkg.sv
// Shared encodings and default sizing for the dot-product controller around the 4x4 array multiplier.
package mult_dot_pkg;

  localparam int unsigned MUL_LAT_DEF = 8;
  localparam int unsigned ACC_W_DEF   = 12;
  localparam int unsigned CNT_W_DEF   = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/mult_lat_timer.sv
// Loadable down-counter with a zero flag; paces the multiplier settling window.
module mult_lat_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero_c
);

  logic [W-1:0] r_cnt;

  // Load wins over decrement; the count parks at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/mult_dot_accum.sv
// Dot-product controller/accumulator wrapped around an external registered 4x4 multiplier.
// Define MULT_DOT_SAT_EN to clamp the accumulator at all-ones on carry-out instead of wrapping.
module mult_dot_accum
  import mult_dot_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_last,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam int unsigned TMR_W = $clog2(MUL_LAT) + 1;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] CNT_CLOSE = CNT_W'((2 ** CNT_W) - 2);
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(MUL_LAT - 1);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [3:0]       r_mul_a;
  logic [3:0]       r_mul_b;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_last;

  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_sample;
  logic             w_take;
  logic             w_tmr_dec;
  logic             w_tmr_zero;
  logic [SUM_W-1:0] w_sum;
  logic [ACC_W-1:0] w_acc_nxt;

  mult_lat_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (TMR_LOAD),
    .i_dec      (w_tmr_dec),
    .o_zero_c   (w_tmr_zero)
  );

  assign w_tmr_dec = (r_state == ST_WAIT);

  // Next state and the three datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_tmr_zero) begin
          w_sample    = 1'b1;
          w_state_nxt = r_last ? ST_DONE : ST_IDLE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_take      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // One extra bit captures the accumulator carry-out.
  assign w_sum = {1'b0, r_acc} + SUM_W'(mul_p);

`ifdef MULT_DOT_SAT_EN
  assign w_acc_nxt = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
`else
  assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif

  // Handshake flags track the next state so both are clean flop outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_last  <= 1'b0;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      // Operands only change on accept, so the multiplier sees stable inputs through WAIT.
      if (w_accept) begin
        r_mul_a <= in_a;
        r_mul_b <= in_b;
        r_last  <= in_last | (r_count == CNT_CLOSE);
      end
      if (w_sample) begin
        r_acc   <= w_acc_nxt;
        r_count <= r_count + CNT_W'(1);
        r_ovf   <= r_ovf | w_sum[ACC_W];
      end else if (w_take) begin
        r_acc   <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign out_acc   = r_acc;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_mult_dot_accum.sv
// Scoreboard bench for mult_dot_accum with a pipelined multiplier model and an 8-bit-accumulator instance.
module tb_mult_dot_accum;
  import mult_dot_pkg::*;

  localparam int unsigned MUL_LAT   = MUL_LAT_DEF;
  localparam int unsigned ACC_W     = ACC_W_DEF;
  localparam int unsigned CNT_W     = CNT_W_DEF;
  localparam int          MAX_PAIRS = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [3:0]       in_a = '0, in_b = '0, mul_a, mul_b;
  logic [7:0]       mul_p;
  logic             out_valid, out_ready = 1'b0, out_ovf;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;

  mult_dot_accum #(.MUL_LAT(MUL_LAT), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );

  // Registered multiplier: product settles MUL_LAT-1 edges after its inputs change.
  logic [7:0] mpipe [0:MUL_LAT-2];
  always @(posedge clk) begin
    mpipe[0] <= 8'(mul_a) * 8'(mul_b);
    for (int i = 1; i < MUL_LAT - 1; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_p = mpipe[MUL_LAT-2];

  // Second instance: 8-bit accumulator, short latency, ideal multiplier.
  logic       s_in_valid = 1'b0, s_in_ready, s_in_last = 1'b0, s_out_valid, s_out_ready = 1'b0, s_out_ovf;
  logic [3:0] s_in_a = '0, s_in_b = '0, s_mul_a, s_mul_b;
  logic [7:0] s_mul_p, s_out_acc;
  logic [CNT_W-1:0] s_out_count;
  assign s_mul_p = 8'(s_mul_a) * 8'(s_mul_b);

  mult_dot_accum #(.MUL_LAT(2), .ACC_W(8), .CNT_W(CNT_W)) dut8 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b),
    .in_last(s_in_last), .mul_a(s_mul_a), .mul_b(s_mul_b), .mul_p(s_mul_p), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_acc(s_out_acc), .out_count(s_out_count), .out_ovf(s_out_ovf)
  );

  typedef struct {longint acc; int cnt; bit ovf;} res_t;
  res_t       exp_q[$];
  int         n_vec = 0, n_err = 0;
  longint     grp_total = 0;
  int         grp_n = 0;
  int         cyc = 0, last_acc_cyc = 0, take_cyc = 0;
  logic [3:0] exp_ma = '0, exp_mb = '0;
  bit         mon_en = 0, bp_force = 0, take_pend = 0, prev_valid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: plain-integer dot product reduced to a W-bit register.
  function automatic longint m_acc(input longint total, input int w);
    longint lim = longint'(1) << w;
`ifdef MULT_DOT_SAT_EN
    return (total >= lim) ? lim - 1 : total;
`else
    return total % lim;
`endif
  endfunction

  function automatic bit m_ovf(input longint total, input int w);
    return total >= (longint'(1) << w);
  endfunction

  function automatic void note_accept(input logic [3:0] a, input logic [3:0] b, input bit last);
    res_t r;
    grp_total += longint'(a) * longint'(b);
    grp_n++;
    exp_ma = a;
    exp_mb = b;
    last_acc_cyc = cyc;
    if (last || grp_n == MAX_PAIRS) begin
      r.acc = m_acc(grp_total, ACC_W);
      r.cnt = grp_n;
      r.ovf = m_ovf(grp_total, ACC_W);
      exp_q.push_back(r);
      grp_total = 0;
      grp_n = 0;
    end
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high.
  task automatic send_pair(input logic [3:0] a, input logic [3:0] b, input bit last);
    int n = 0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 400) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      return;
    end
    @(negedge clk);
    note_accept(a, b, last);
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || take_pend) && n < 600) begin @(negedge clk); n++; end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic send8(input logic [3:0] a, input logic [3:0] b, input bit last);
    int n = 0;
    s_in_a = a; s_in_b = b; s_in_last = last; s_in_valid = 1'b1;
    while (!s_in_ready && n < 100) begin @(negedge clk); n++; end
    chk("acc8_accept", s_in_ready, 1);
    @(negedge clk);
    s_in_valid = 1'b0;
  endtask

  // Consumer ready: random unless the test forces backpressure.
  initial forever begin
    @(negedge clk);
    out_ready = bp_force ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: samples late in each cycle, compares against the scoreboard head.
  always begin
    @(posedge clk);
    #8;
    if (mon_en && !rst) begin
      chk("mul_a_hold", mul_a, exp_ma);
      chk("mul_b_hold", mul_b, exp_mb);
      if (take_pend) begin
        chk("clear_acc", out_acc, 0);
        chk("clear_count", out_count, 0);
        chk("clear_ovf", out_ovf, 0);
        chk("clear_valid", out_valid, 0);
        chk("idle_ready", in_ready, 1);
        take_pend = 0;
      end
      if (out_valid && !prev_valid) chk("valid_latency", cyc - last_acc_cyc, MUL_LAT);
      if (out_valid) begin
        chk("in_ready_in_done", in_ready, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_result", exp_q.size(), 1);
        end else begin
          chk("out_acc", out_acc, exp_q[0].acc);
          chk("out_count", out_count, exp_q[0].cnt);
          chk("out_ovf", out_ovf, exp_q[0].ovf);
          if (out_ready) begin
            void'(exp_q.pop_front());
            take_pend = 1;
            take_cyc = cyc + 1;
          end
        end
      end
      prev_valid = out_valid;
    end else begin
      prev_valid = 0;
      take_pend = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int a0, a1, n;
    int len;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc", out_acc, 0);
    chk("rst_count", out_count, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_mul_a", mul_a, 0);
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);

    // Single full-scale pair
    send_pair(4'd15, 4'd15, 1'b1);
    drain();

    // Back-to-back pairs with valid held high
    send_pair(4'd3, 4'd5, 1'b0);
    a0 = last_acc_cyc;
    send_pair(4'd7, 4'd2, 1'b0);
    a1 = last_acc_cyc;
    chk("throughput_1", a1 - a0, MUL_LAT + 1);
    send_pair(4'd15, 4'd15, 1'b1);
    chk("throughput_2", last_acc_cyc - a1, MUL_LAT + 1);
    drain();

    // Backpressure held in DONE
    bp_force = 1;
    send_pair(4'd9, 4'd6, 1'b0);
    send_pair(4'd4, 4'd11, 1'b1);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_reach_done", out_valid, 1);
    repeat (5) @(negedge clk);
    bp_force = 0;
    drain();

    // Forced close on the final countable pair
    bp_force = 1;
    for (int i = 0; i < MAX_PAIRS; i++) send_pair(4'd1, 4'd1, 1'b0);
    in_a = 4'd2; in_b = 4'd2; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("no_accept_16th", in_ready, 0);
      @(negedge clk);
    end
    bp_force = 0;
    send_pair(4'd2, 4'd2, 1'b1);
    chk("accept_after_take", last_acc_cyc > take_cyc, 1);
    drain();

    // Reset in the middle of WAIT of the second pair
    send_pair(4'd5, 4'd5, 1'b0);
    send_pair(4'd4, 4'd4, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_ma = '0;
    exp_mb = '0;
    @(negedge clk);
    chk("midrst_acc", out_acc, 0);
    chk("midrst_count", out_count, 0);
    chk("midrst_mul_a", mul_a, 0);
    chk("midrst_mul_b", mul_b, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst = 1'b0;
    grp_total = 0;
    grp_n = 0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_idle", in_ready, 1);
    send_pair(4'd2, 4'd3, 1'b1);
    drain();

    // 8-bit accumulator: wrap or clamp
    send8(4'd15, 4'd15, 1'b0);
    send8(4'd15, 4'd15, 1'b1);
    n = 0;
    while (!s_out_valid && n < 20) begin @(negedge clk); n++; end
    chk("acc8_valid", s_out_valid, 1);
    chk("acc8_acc", s_out_acc, m_acc(450, 8));
    chk("acc8_ovf", s_out_ovf, m_ovf(450, 8));
    chk("acc8_count", s_out_count, 2);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    chk("acc8_clear", s_out_acc, 0);

    // Randomized groups with random valid gaps
    for (int g = 0; g < 25; g++) begin
      len = $urandom_range(1, 17);
      for (int k = 0; k < len; k++) begin
        send_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), k == len - 1);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
      end
    end
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_dot_accum.md
Name: mult_dot_accum

Overview:
- Controller and accumulator that sits directly upstream and downstream of the 4x4 registered array multiplier.
- Accepts a stream of 4-bit operand pairs and drives each pair onto the multiplier's inputs.
- Holds each pair stable for the multiplier's settling latency, then samples the 8-bit product and accumulates it.
- Emits the dot-product sum when the pair flagged last completes; results leave on a valid/ready interface.

Parameters:
- MUL_LAT, 8, cycles operands are held stable before mul_p is sampled (>=1).
- ACC_W, 12, accumulator width (>=8).
- CNT_W, 4, pair-counter width; at most 2^CNT_W-1 pairs per dot product.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept a pair
- in_a  in  4  multiplicand
- in_b  in  4  multiplier
- in_last  in  1  final pair of the dot product
- mul_a  out  4  registered operand to multiplier inp1
- mul_b  out  4  registered operand to multiplier inp2
- mul_p  in  8  multiplier product
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_acc  out  ACC_W  accumulated sum
- out_count  out  CNT_W  number of pairs accumulated
- out_ovf  out  1  sticky: accumulator carry-out occurred during this dot product

Behaviour:
- One clock clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE. mul_a, mul_b, out_acc, out_count, out_ovf, out_valid, internal counter and last flag all 0. in_ready=0 during the reset cycle, 1 after.
- A synchronous rst in any state, including mid-WAIT or DONE, discards the pending pair and the partial sum. There is no flush or output.
- FSM states: IDLE, WAIT, DONE.
- in_ready is 1 only in IDLE. out_valid is 1 only in DONE.
- IDLE: on in_valid&in_ready at edge E0:
  - register mul_a<=in_a, mul_b<=in_b;
  - latch last = in_last OR (out_count == 2^CNT_W-2), i.e. forced close on the final countable pair;
  - load timer with MUL_LAT-1; go to WAIT.
- WAIT: timer decrements each edge. At the edge where timer==0 (edge E0+MUL_LAT):
  - out_acc <= out_acc + mul_p, where mul_p is zero-extended to ACC_W;
  - out_count <= out_count+1;
  - out_ovf <= out_ovf | carry-out;
  - next state = DONE if last, else IDLE.
- mul_a and mul_b hold their value in every state until the next accept. The multiplier input never glitches mid-WAIT.
- Throughput: one pair per MUL_LAT+1 cycles. out_valid rises MUL_LAT cycles after the accepting edge of the last pair.
- DONE: out_acc, out_count and out_ovf are held stable while out_valid=1 and out_ready=0. On out_valid&out_ready, clear acc, count and ovf, and go to IDLE. A new pair is accepted no earlier than the following cycle.
- in_valid deasserted in IDLE: stay in IDLE, accumulator retained. There is no timeout.
- Arithmetic is unsigned. Without saturation, the sum wraps modulo 2^ACC_W.

Optional Feature:
- Macro MULT_DOT_SAT_EN.
- Defined: an addition that would carry out clamps out_acc to all-ones, and out_ovf still sets.
- Undefined: out_acc wraps modulo 2^ACC_W, and out_ovf sets on carry-out.

Decomposition:
- Shared package/header mult_dot_pkg holds:
  - state encodings IDLE=2'd0, WAIT=2'd1, DONE=2'd2;
  - default constants MUL_LAT_DEF=8, ACC_W_DEF=12, CNT_W_DEF=4.
- One natural sub-module: mult_lat_timer. It is a loadable down-counter with a zero flag, width $clog2(MUL_LAT)+1.
- The multiplier itself is instantiated alongside this block at the next level up, not inside it.

Test Plan:
- Single pair in_a=15, in_b=15, in_last=1, with the real multiplier attached:
  - out_valid rises exactly 8 cycles after accept;
  - out_acc=225, out_count=1, out_ovf=0.
- Pairs (3,5), (7,2), (15,15), last on the third, in_valid held high:
  - out_acc=254, out_count=3;
  - in_ready pulses once per 9 cycles;
  - mul_a and mul_b are stable throughout each WAIT.
- ACC_W=8, pairs (15,15), (15,15)+last:
  - without MULT_DOT_SAT_EN: out_acc=194, out_ovf=1;
  - with MULT_DOT_SAT_EN: out_acc=255, out_ovf=1.
- 15 pairs of (1,1) with in_last=0 throughout: forced close with out_count=15, out_acc=15. The 16th pair is not accepted until the result is taken.
- Backpressure: out_ready=0 for 5 cycles in DONE:
  - out_valid and all outputs are held, and in_ready=0;
  - on handshake, state returns to IDLE and acc, count and ovf read 0.
- rst asserted 3 cycles into WAIT of the second pair:
  - next cycle: out_acc=0, state=IDLE, mul_a=mul_b=0;
  - a subsequent single pair (2,3)+last yields out_acc=6.
